// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// mem_wb_stage_pkg : load-type and write-back-source encodings for MEM/WB
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

    // Load type carried down the pipe; codes 5-7 are treated as a word load.
    typedef enum logic [2:0] {
        DM_W  = 3'd0,
        DM_H  = 3'd1,
        DM_HU = 3'd2,
        DM_B  = 3'd3,
        DM_BU = 3'd4
    } dm_op_e;

    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_DM   = 2'd1,
        WD_PC8  = 2'd2,
        WD_ZERO = 2'd3
    } wd_sel_e;

    localparam logic [31:0] PC_LINK_OFFSET = 32'd8;

endpackage : mem_wb_stage_pkg

`default_nettype wire

// File: rtl/mem_wb_stage_load_ext.sv
// ============================================================================
// load_ext : little-endian byte/half extraction with sign/zero extension
// Revision: 1.0
// ============================================================================
`default_nettype none

module load_ext
    import mem_wb_stage_pkg::*;
(
    input  logic [31:0] dm_out_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  dm_op_i,
    output logic [31:0] data_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = dm_out_i[7:0];
        case (byte_off_i)
            2'd0:    byte_sel = dm_out_i[7:0];
            2'd1:    byte_sel = dm_out_i[15:8];
            2'd2:    byte_sel = dm_out_i[23:16];
            default: byte_sel = dm_out_i[31:24];
        endcase
        half_sel = byte_off_i[1] ? dm_out_i[31:16] : dm_out_i[15:0];
    end

    // The data path still extracts on a misaligned access; only the flag reports it.
    always_comb begin
        data_o       = dm_out_i;
        misaligned_o = 1'b0;
        case (dm_op_i)
            DM_H: begin
                data_o       = {{16{half_sel[15]}}, half_sel};
                misaligned_o = byte_off_i[0];
            end
            DM_HU: begin
                data_o       = {16'h0000, half_sel};
                misaligned_o = byte_off_i[0];
            end
            DM_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            DM_BU:   data_o = {24'h000000, byte_sel};
            default: begin
                data_o       = dm_out_i;
                misaligned_o = |byte_off_i;
            end
        endcase
    end

endmodule : load_ext

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : MEM/WB pipeline registers, write-back mux, retire counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
    import mem_wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        M_valid,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Instr,
    input  logic [31:0] M_ALUOut,
    input  logic [31:0] M_DMOut,
    input  logic [2:0]  M_DMOp,
    input  logic [1:0]  M_WDSel,
    input  logic [4:0]  M_RegWA,
    input  logic        M_RegWE,
    output logic        W_valid,
    output logic        W_RegWE,
    output logic        W_AdEL,
    output logic [4:0]  W_RegWA,
    output logic [31:0] W_PC,
    output logic [31:0] W_Instr,
    output logic [31:0] W_WD,
    output logic [31:0] W_retired
);

    logic [31:0] ld_data;
    logic        ld_misaligned;
    logic        misaligned;
    logic [31:0] wd_d;
    logic        regwe_d;
    logic        retire_d;

    logic        valid_q;
    logic        regwe_q;
    logic        adel_q;
    logic [4:0]  regwa_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] wd_q;
    logic [31:0] retired_q;

    load_ext u_load_ext (
        .dm_out_i     (M_DMOut),
        .byte_off_i   (M_ALUOut[1:0]),
        .dm_op_i      (M_DMOp),
        .data_o       (ld_data),
        .misaligned_o (ld_misaligned)
    );

    // Alignment only matters when the memory word is actually written back.
    assign misaligned = ld_misaligned & (M_WDSel == WD_DM);

    always_comb begin
        wd_d = 32'h0000_0000;
        case (M_WDSel)
            WD_ALU:  wd_d = M_ALUOut;
            WD_DM:   wd_d = ld_data;
            WD_PC8:  wd_d = M_PC + PC_LINK_OFFSET;
            default: wd_d = 32'h0000_0000;
        endcase
    end

    assign regwe_d  = M_RegWE & M_valid & (|M_RegWA) & ~misaligned;
    assign retire_d = M_valid & ~misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            regwe_q   <= 1'b0;
            adel_q    <= 1'b0;
            regwa_q   <= 5'd0;
            pc_q      <= 32'h0;
            instr_q   <= 32'h0;
            wd_q      <= 32'h0;
            retired_q <= 32'h0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            regwe_q   <= 1'b0;
            adel_q    <= 1'b0;
            regwa_q   <= 5'd0;
            pc_q      <= 32'h0;
            instr_q   <= 32'h0;
            wd_q      <= 32'h0;
        end else if (!stall) begin
            valid_q   <= M_valid;
            regwe_q   <= regwe_d;
            adel_q    <= misaligned;
            regwa_q   <= M_RegWA;
            pc_q      <= M_PC;
            instr_q   <= M_Instr;
            wd_q      <= wd_d;
            retired_q <= retired_q + {31'd0, retire_d};
        end
    end

    assign W_valid   = valid_q;
    assign W_RegWE   = regwe_q;
    assign W_AdEL    = adel_q;
    assign W_RegWA   = regwa_q;
    assign W_PC      = pc_q;
    assign W_Instr   = instr_q;
    assign W_WD      = wd_q;
    assign W_retired = retired_q;

endmodule : mem_wb_stage

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : directed self-checking bench for mem_wb_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        M_valid;
    logic [31:0] M_PC, M_Instr, M_ALUOut, M_DMOut;
    logic [2:0]  M_DMOp;
    logic [1:0]  M_WDSel;
    logic [4:0]  M_RegWA;
    logic        M_RegWE;
    logic        W_valid, W_RegWE, W_AdEL;
    logic [4:0]  W_RegWA;
    logic [31:0] W_PC, W_Instr, W_WD, W_retired;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ret;
    logic [31:0] held_pc, held_wd;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .M_valid   (M_valid),
        .M_PC      (M_PC),
        .M_Instr   (M_Instr),
        .M_ALUOut  (M_ALUOut),
        .M_DMOut   (M_DMOut),
        .M_DMOp    (M_DMOp),
        .M_WDSel   (M_WDSel),
        .M_RegWA   (M_RegWA),
        .M_RegWE   (M_RegWE),
        .W_valid   (W_valid),
        .W_RegWE   (W_RegWE),
        .W_AdEL    (W_AdEL),
        .W_RegWA   (W_RegWA),
        .W_PC      (W_PC),
        .W_Instr   (W_Instr),
        .W_WD      (W_WD),
        .W_retired (W_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] dmo, input logic [2:0] op, input logic [1:0] wds,
                         input logic [4:0] wa, input logic we);
        M_valid  = v;
        M_PC     = pc;
        M_Instr  = pc ^ 32'hA5A5_0000;
        M_ALUOut = alu;
        M_DMOut  = dmo;
        M_DMOp   = op;
        M_WDSel  = wds;
        M_RegWA  = wa;
        M_RegWE  = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, {31'd0, W_valid}, 32'd0);
        chk({tag, ".regwe"}, {31'd0, W_RegWE}, 32'd0);
        chk({tag, ".adel"},  {31'd0, W_AdEL},  32'd0);
        chk({tag, ".regwa"}, {27'd0, W_RegWA}, 32'd0);
        chk({tag, ".pc"},    W_PC,    32'd0);
        chk({tag, ".instr"}, W_Instr, 32'd0);
        chk({tag, ".wd"},    W_WD,    32'd0);
    endtask

    // Valid load of a word through the DM path with one byte-offset/op combination.
    task automatic ld(input string tag, input logic [31:0] dmo, input logic [2:0] op,
                      input logic [1:0] off, input logic [31:0] exp_wd);
        drive(1'b1, 32'h0000_4000, {30'h40, off}, dmo, op, 2'd1, 5'd9, 1'b1);
        step();
        exp_ret = exp_ret + 32'd1;
        chk(tag, W_WD, exp_wd);
        chk({tag, ".ret"}, W_retired, exp_ret);
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 32'h0000_3000, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 5'd3, 1'b1);
        exp_ret = 32'd0;

        // Edges while reset is low are ignored.
        step();
        step();
        chk_zero("rst");
        chk("rst.ret", W_retired, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 3'd0, 2'd0, 5'd3, 1'b1);
            step();
        end
        exp_ret = 32'd5;
        chk("alu.wd",    W_WD,      32'h0000_0104);
        chk("alu.pc",    W_PC,      32'h0000_3010);
        chk("alu.instr", W_Instr,   32'hA5A5_3010);
        chk("alu.regwe", {31'd0, W_RegWE}, 32'd1);
        chk("alu.regwa", {27'd0, W_RegWA}, 32'd3);
        chk("alu.ret",   W_retired, exp_ret);

        // Asynchronous reset mid-run clears outputs before the next edge.
        #3;
        reset = 1'b0;
        #1;
        chk_zero("arst");
        chk("arst.ret", W_retired, 32'd0);
        step();
        chk("arst.hold", {31'd0, W_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_ret = 32'd0;
        drive(1'b1, 32'h0000_3100, 32'hCAFE_0000, 32'h0, 3'd0, 2'd0, 5'd4, 1'b1);
        step();
        exp_ret = 32'd1;
        chk("post.valid", {31'd0, W_valid}, 32'd1);
        chk("post.wd",    W_WD,      32'hCAFE_0000);
        chk("post.ret",   W_retired, exp_ret);

        ld("b0",  32'h80FF_7F01, 3'd3, 2'd0, 32'h0000_0001);
        ld("b1",  32'h80FF_7F01, 3'd3, 2'd1, 32'h0000_007F);
        ld("b2",  32'h80FF_7F01, 3'd3, 2'd2, 32'hFFFF_FFFF);
        ld("b3",  32'h80FF_7F01, 3'd3, 2'd3, 32'hFFFF_FF80);
        ld("bu3", 32'h80FF_7F01, 3'd4, 2'd3, 32'h0000_0080);
        ld("h2",  32'h8001_FFFE, 3'd1, 2'd2, 32'hFFFF_8001);
        ld("hu0", 32'h8001_FFFE, 3'd2, 2'd0, 32'h0000_FFFE);
        ld("op7", 32'h8001_FFFE, 3'd7, 2'd0, 32'h8001_FFFE);

        // Misaligned half load: flagged, not written, not retired.
        drive(1'b1, 32'h0000_4000, 32'h0000_0101, 32'h8001_FFFE, 3'd1, 2'd1, 5'd9, 1'b1);
        step();
        chk("mis.adel",  {31'd0, W_AdEL},  32'd1);
        chk("mis.regwe", {31'd0, W_RegWE}, 32'd0);
        chk("mis.wd",    W_WD,      32'hFFFF_FFFE);
        chk("mis.ret",   W_retired, exp_ret);

        // Misaligned word through the ALU path is not an address error.
        drive(1'b1, 32'h0000_4004, 32'h0000_0102, 32'h0, 3'd0, 2'd0, 5'd9, 1'b1);
        step();
        exp_ret = exp_ret + 32'd1;
        chk("aluw.adel", {31'd0, W_AdEL}, 32'd0);
        chk("aluw.ret",  W_retired, exp_ret);

        drive(1'b1, 32'h0000_3000, 32'h0000_0010, 32'h0, 3'd0, 2'd2, 5'd31, 1'b1);
        step();
        exp_ret = exp_ret + 32'd1;
        chk("pc8.wd", W_WD, 32'h0000_3008);

        drive(1'b1, 32'h0000_3004, 32'h0000_0010, 32'h0, 3'd0, 2'd3, 5'd5, 1'b1);
        step();
        exp_ret = exp_ret + 32'd1;
        chk("wd3.wd", W_WD, 32'h0000_0000);

        drive(1'b1, 32'h0000_3008, 32'h0000_0055, 32'h0, 3'd0, 2'd0, 5'd0, 1'b1);
        step();
        exp_ret = exp_ret + 32'd1;
        chk("r0.regwe", {31'd0, W_RegWE}, 32'd0);
        chk("r0.ret",   W_retired, exp_ret);

        drive(1'b0, 32'h0000_300C, 32'h0000_0066, 32'h0, 3'd0, 2'd0, 5'd6, 1'b1);
        step();
        chk("inv.regwe", {31'd0, W_RegWE}, 32'd0);
        chk("inv.ret",   W_retired, exp_ret);

        // Stall holds W for three edges while M changes underneath.
        drive(1'b1, 32'h0000_5000, 32'h0000_7777, 32'h0, 3'd0, 2'd0, 5'd7, 1'b1);
        step();
        exp_ret = exp_ret + 32'd1;
        held_pc = 32'h0000_5000;
        held_wd = 32'h0000_7777;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_6000 + 32'(i), 32'h0000_8888, 32'h0, 3'd0, 2'd0, 5'd8, 1'b1);
            step();
            chk("stall.pc",  W_PC,      held_pc);
            chk("stall.wd",  W_WD,      held_wd);
            chk("stall.ret", W_retired, exp_ret);
        end
        flush = 1'b1;
        step();
        chk_zero("flush");
        chk("flush.ret", W_retired, exp_ret);
        stall = 1'b0;
        flush = 1'b0;

        // Counter wrap from a preloaded value.
        @(negedge clk);
        dut.retired_q = 32'hFFFF_FFFE;
        drive(1'b1, 32'h0000_7000, 32'h1, 32'h0, 3'd0, 2'd0, 5'd2, 1'b1);
        step();
        chk("wrap0", W_retired, 32'hFFFF_FFFF);
        step();
        chk("wrap1", W_retired, 32'h0000_0000);
        step();
        chk("wrap2", W_retired, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_wb_stage

`default_nettype wire
